// File: rtl/matrix_operand_sequencer.sv
// Streams (A[i][k], B[k][j]) pairs for C = A*B with k innermost, then j, then i.
// Matrices are captured on an accepted start; beats use a valid/ready handshake.
module matrix_operand_sequencer #(
  parameter int N = 2,
  parameter int W = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*N*W-1:0]    matrix_a,
  input  logic [N*N*W-1:0]    matrix_b,
  input  logic                out_ready,
  input  logic                abort,
  output logic                out_valid,
  output logic [W-1:0]        a_elem,
  output logic [W-1:0]        b_elem,
  output logic [IW-1:0]       row,
  output logic [IW-1:0]       col,
  output logic [IW-1:0]       kidx,
  output logic                first,
  output logic                last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IW-1:0] IMAX = IW'(N - 1);

  state_t               state;
  logic [N*N*W-1:0]     a_reg;
  logic [N*N*W-1:0]     b_reg;
  logic [W-1:0]         a_mem [N][N];
  logic [W-1:0]         b_mem [N][N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
        assign a_mem[gi][gj] = a_reg[(gi*N+gj)*W +: W];
        assign b_mem[gi][gj] = b_reg[(gi*N+gj)*W +: W];
      end
    end
  endgenerate

  logic          k_wrap, j_wrap, i_wrap, final_beat;
  logic [IW-1:0] k_next, col_next, row_next;

  // Explicit wrap at N-1 so non-power-of-2 sizes never reach an illegal index.
  always_comb begin
    k_wrap     = (kidx == IMAX);
    j_wrap     = (col == IMAX);
    i_wrap     = (row == IMAX);
    final_beat = k_wrap && j_wrap && i_wrap;
    k_next     = k_wrap ? '0 : kidx + 1'b1;
    col_next   = col;
    row_next   = row;
    if (k_wrap) begin
      col_next = j_wrap ? '0 : col + 1'b1;
      if (j_wrap)
        row_next = i_wrap ? '0 : row + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      out_valid <= 1'b0;
      a_elem    <= '0;
      b_elem    <= '0;
      row       <= '0;
      col       <= '0;
      kidx      <= '0;
      first     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            a_reg     <= matrix_a;
            b_reg     <= matrix_b;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            row       <= '0;
            col       <= '0;
            kidx      <= '0;
            // First beat comes straight from the inputs being captured this edge.
            a_elem    <= matrix_a[W-1:0];
            b_elem    <= matrix_b[W-1:0];
            first     <= 1'b1;
            last      <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            first     <= 1'b0;
            last      <= 1'b0;
          end else if (out_ready) begin
            if (final_beat) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              first     <= 1'b0;
              last      <= 1'b0;
            end else begin
              row    <= row_next;
              col    <= col_next;
              kidx   <= k_next;
              a_elem <= a_mem[row_next][k_next];
              b_elem <= b_mem[k_next][col_next];
              first  <= (k_next == '0);
              last   <= (k_next == IMAX);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Directed bench: N=2/W=3 stream, stalls, interference, abort, reset; N=3/W=8 product check.
module tb_matrix_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          failures = 0;

  // N=2, W=3 instance
  logic        start, out_ready, abort;
  logic [11:0] matrix_a, matrix_b;
  logic        out_valid, first, last, busy, done;
  logic [2:0]  a_elem, b_elem;
  logic [0:0]  row, col, kidx;

  // N=3, W=8 instance
  logic        start3, out_ready3, abort3;
  logic [71:0] matrix_a3, matrix_b3;
  logic        out_valid3, first3, last3, busy3, done3;
  logic [7:0]  a_elem3, b_elem3;
  logic [1:0]  row3, col3, kidx3;

  always #5 clk = ~clk;

  matrix_operand_sequencer #(.N(2), .W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_a(matrix_a), .matrix_b(matrix_b),
    .out_ready(out_ready), .abort(abort), .out_valid(out_valid), .a_elem(a_elem),
    .b_elem(b_elem), .row(row), .col(col), .kidx(kidx), .first(first), .last(last),
    .busy(busy), .done(done)
  );

  matrix_operand_sequencer #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .matrix_a(matrix_a3), .matrix_b(matrix_b3),
    .out_ready(out_ready3), .abort(abort3), .out_valid(out_valid3), .a_elem(a_elem3),
    .b_elem(b_elem3), .row(row3), .col(col3), .kidx(kidx3), .first(first3), .last(last3),
    .busy(busy3), .done(done3)
  );

  int exp_a [8] = '{1, 2, 1, 2, 3, 4, 3, 4};
  int exp_b [8] = '{5, 7, 6, 1, 5, 7, 6, 1};

  function automatic logic [11:0] pack2(input int a00, input int a01, input int a10, input int a11);
    return {3'(a11), 3'(a10), 3'(a01), 3'(a00)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input int b);
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " busy"},  64'(busy),      64'd1);
    chk({tag, " done"},  64'(done),      64'd0);
    chk({tag, " a"},     64'(a_elem),    64'(exp_a[b]));
    chk({tag, " b"},     64'(b_elem),    64'(exp_b[b]));
    chk({tag, " idx"},   64'({row, col, kidx}), 64'(b));
    chk({tag, " first"}, 64'(first),     64'((b % 2) == 0));
    chk({tag, " last"},  64'(last),      64'((b % 2) == 1));
    $display("beat %s #%0d a=%0d b=%0d row=%0d col=%0d k=%0d", tag, b, a_elem, b_elem, row, col, kidx);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " valid"}, 64'(out_valid), 64'd0);
    chk({tag, " busy"},  64'(busy),      64'd0);
    chk({tag, " done"},  64'(done),      64'd0);
  endtask

  // Launch from a negedge; returns at the negedge of cycle 1 (first beat visible).
  task automatic start_seq();
    matrix_a = pack2(1, 2, 3, 4);
    matrix_b = pack2(5, 6, 7, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_basic(input string tag);
    start_seq();
    for (int b = 0; b < 8; b++) begin
      check_beat(tag, b);
      tick();
    end
    chk({tag, " done pulse"}, 64'(done), 64'd1);
    chk({tag, " done valid"}, 64'(out_valid), 64'd0);
    chk({tag, " done busy"},  64'(busy), 64'd0);
    tick();
    check_idle({tag, " after done"});
  endtask

  int am [3][3];
  int bm [3][3];
  int cm [3][3];

  initial begin
    int b;
    logic rdy;
    int acc, beats3, dcount3, overlap3, ei, ej, ek;

    rst_n = 1'b0; start = 0; abort = 0; out_ready = 1; matrix_a = '0; matrix_b = '0;
    start3 = 0; abort3 = 0; out_ready3 = 1; matrix_a3 = '0; matrix_b3 = '0;
    tick(); tick();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset elems",     64'({a_elem, b_elem}), 64'd0);
    chk("reset idx",       64'({row, col, kidx}), 64'd0);
    chk("reset markers",   64'({first, last, busy, done}), 64'd0);
    chk("reset3 all",      64'({out_valid3, a_elem3, b_elem3, row3, col3, kidx3, first3, last3, busy3, done3}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic stream
    run_basic("basic");

    // Back-pressure: stall cycles 2-4 and 6, done at cycle 13
    start_seq();
    b = 0;
    for (int c = 1; c <= 12; c++) begin
      check_beat("bp", b);
      rdy = !(c == 2 || c == 3 || c == 4 || c == 6);
      out_ready = rdy;
      tick();
      if (rdy) b++;
    end
    out_ready = 1'b1;
    chk("bp done pulse", 64'(done), 64'd1);
    tick();
    check_idle("bp after done");

    // Interference: matrix change + start during RUN, start in DONE
    start_seq();
    for (int i = 0; i < 8; i++) begin
      check_beat("intf", i);
      if (i == 2) begin
        matrix_a = pack2(7, 7, 7, 7);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("intf done pulse", 64'(done), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("intf start in done");
    tick();
    check_idle("intf no queued start");

    // Abort at beat 5 (priority over the transfer)
    start_seq();
    for (int i = 0; i < 5; i++) begin
      check_beat("abort", i);
      if (i == 4) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check_idle("abort next");
    tick();
    check_idle("abort no done");

    // Asynchronous reset mid-run
    start_seq();
    check_beat("rst", 0);
    tick();
    check_beat("rst", 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid",  64'(out_valid), 64'd0);
    chk("async rst elems",  64'({a_elem, b_elem}), 64'd0);
    chk("async rst idx",    64'({row, col, kidx}), 64'd0);
    chk("async rst marks",  64'({first, last, busy, done}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post rst idle");
    run_basic("post rst");

    // N=3, W=8 random matrices with random stalls
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        am[r][c] = int'($urandom_range(0, 255));
        bm[r][c] = int'($urandom_range(0, 255));
        matrix_a3[(r*3+c)*8 +: 8] = 8'(am[r][c]);
        matrix_b3[(r*3+c)*8 +: 8] = 8'(bm[r][c]);
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        cm[r][c] = 0;
        for (int k = 0; k < 3; k++) cm[r][c] += am[r][k] * bm[k][c];
      end
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    acc = 0; beats3 = 0; dcount3 = 0; overlap3 = 0; ei = 0; ej = 0; ek = 0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (done3) dcount3++;
      if (done3 && busy3) overlap3++;
      out_ready3 = ($urandom_range(0, 3) != 0);
      if (out_valid3 && out_ready3) begin
        chk("n3 idx",   64'({row3, col3, kidx3}), 64'({2'(ei), 2'(ej), 2'(ek)}));
        chk("n3 a",     64'(a_elem3), 64'(am[ei][ek]));
        chk("n3 b",     64'(b_elem3), 64'(bm[ek][ej]));
        chk("n3 first", 64'(first3), 64'(ek == 0));
        chk("n3 last",  64'(last3),  64'(ek == 2));
        acc = (first3 ? 0 : acc) + int'(a_elem3) * int'(b_elem3);
        if (last3) begin
          chk("n3 C entry", 64'(acc), 64'(cm[ei][ej]));
          $display("n3 C[%0d][%0d]=%0d", row3, col3, acc);
        end
        beats3++;
        ek++;
        if (ek == 3) begin ek = 0; ej++; end
        if (ej == 3) begin ej = 0; ei++; end
      end
      tick();
    end
    out_ready3 = 1'b1;
    chk("n3 beats",       64'(beats3),   64'd27);
    chk("n3 done once",   64'(dcount3),  64'd1);
    chk("n3 done&busy",   64'(overlap3), 64'd0);
    chk("n3 idle at end", 64'({out_valid3, busy3, done3}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_operand_sequencer.md
# matrix_operand_sequencer

Parametrised operand sequencer for the matrix multiplier: captures an N×N matrix A and an N×N matrix B, then streams the ordered (A[i][k], B[k][j]) element pairs the multiply-accumulate stage needs to form every entry of C = A·B. It sits between the matrix input registers and the MAC datapath. Unlike the fixed 2×2, 3-bit, free-running selector it replaces, it supports any matrix size and element width, uses a valid/ready handshake with back-pressure, and provides start/busy/done control. It also marks dot-product boundaries so the accumulator can clear and commit results without its own counter.

## Interface
Parameters:
- N, default 2, matrix dimension; legal range N ≥ 2.
- W, default 3, element width in bits; legal range W ≥ 1.
- Derived (localparam, not overridable): IW = max(1, $clog2(N)), the index width.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new sequence; sampled only in IDLE.
- matrix_a  input  N*N*W  element (r,c) at bits [(r*N+c)*W +: W]; captured on accepted start.
- matrix_b  input  N*N*W  same packing as matrix_a; captured on accepted start.
- out_ready  input  1  downstream accepts the current beat.
- abort  input  1  synchronous cancel; returns the block to IDLE.
- out_valid  output  1  a_elem/b_elem/indices/markers are valid.
- a_elem  output  W  A[i][k].
- b_elem  output  W  B[k][j].
- row  output  IW  i of the C entry being formed.
- col  output  IW  j of the C entry being formed.
- kidx  output  IW  k term index.
- first  output  1  kidx == 0; accumulator must load, not add.
- last  output  1  kidx == N-1; accumulator result for C[row][col] is complete.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start: capture both matrices into internal registers and set i = j = k = 0.
  - Input changes after capture have no effect on the running sequence.
- RUN: out_valid = 1. The beat is transferred on any cycle with out_valid && out_ready.
  - On transfer, advance the loop with k innermost, then j, then i:
    - k++ ; when k wraps from N-1 to 0, j++ ; when j wraps, i++.
  - The transfer with i = j = k = N-1 is the final beat: go to DONE.
  - No transfer (out_ready = 0): all outputs hold exactly stable.
- DONE: done = 1 and out_valid = 0 for one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE, with no queuing.
- Output values:
  - a_elem = A[row][kidx], b_elem = B[kidx][col]; registered, not combinational from the inputs.
  - first and last are decoded from the registered kidx.
- Total beats per sequence: N³. For N = 2 these are pairs 0–7, in the same order as the legacy entry numbering.
- abort:
  - In RUN or DONE: next state IDLE; out_valid, busy and done go to 0; no done pulse.
  - abort has priority over start and over a simultaneous transfer.
  - abort in IDLE has no effect.
- Reset (asynchronous, rst_n = 0): state = IDLE, and every output is 0 (out_valid, a_elem, b_elem, row, col, kidx, first, last, busy, done). The captured matrices are also cleared.
  - Reset during RUN discards the sequence and emits no done pulse.
- Index counters never exceed N-1; for non-power-of-2 N the wrap is explicit and does not rely on overflow.

## Timing
- start accepted at edge t → out_valid = 1 and busy = 1 from cycle t+1, presenting beat (0,0,0).
- With out_ready held at 1: one beat per cycle; beats occupy cycles t+1 … t+N³; done = 1 in cycle t+N³+1; IDLE from t+N³+2.
  - A new start is accepted at the earliest in cycle t+N³+2.
- Back-pressure adds exactly one cycle per stalled cycle, with no loss or duplication of beats.
- busy is low in DONE; done and busy are never high together.

## Test plan
- Basic N=2, W=3, out_ready=1: A = [[1,2],[3,4]], B = [[5,6],[7,1]], start at cycle 0.
  - Required (a,b) per cycle 1–8: (1,5) (2,7) (1,6) (2,1) (3,5) (4,7) (3,6) (4,1).
  - first on beats 1,3,5,7; last on beats 2,4,6,8; done only at cycle 9.
- Back-pressure: same stimulus, out_ready low on cycles 2–4 and 6.
  - Outputs hold during stalls; the same 8 pairs arrive in order; done at cycle 13.
- Start/matrix interference: change matrix_a and pulse start during RUN.
  - No effect on the stream and no restart; a second start in DONE is also ignored.
- Abort and reset: abort at beat 5 → IDLE next cycle, no done pulse.
  - rst_n low mid-RUN → all outputs 0 immediately, asynchronously to clk.
  - A new start afterwards runs a clean 8-beat sequence.
- N=3, W=8, random matrices: 27 beats with row/col/kidx sweeping k fastest.
  - Scoreboard-summed products, grouped by first/last, equal a reference A·B.
  - done arrives exactly once.
